// File: rtl/math_pkg.sv
// Shared types for the math library.
// Operand sign modes and divider FSM states.
package math_pkg;

    typedef enum logic [1:0] {
        TC_UU,
        TC_SU,
        TC_US,
        TC_SS
    } tc_mode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX
    } div_state_e;

endpackage

// File: rtl/div_ss_step.sv
// One restoring-division step.
// Shifts the next dividend bit into the remainder and subtracts |b| when it fits.
module div_ss_step #(
    parameter int BDw = 4
) (
    input  logic [BDw-1:0] i_rem,
    input  logic           i_bit,
    input  logic [BDw-1:0] i_b,
    output logic [BDw:0]   o_rem,
    output logic           o_q
);

    logic [BDw:0] w_sh;
    logic [BDw:0] w_b;

    // The incoming remainder is always below |b|, so its top bit is zero
    always_comb begin
        w_sh  = {i_rem, i_bit};
        w_b   = {1'b0, i_b};
        o_q   = (w_sh >= w_b);
        o_rem = o_q ? (w_sh - w_b) : w_sh;
    end

endmodule

// File: rtl/div_ss.sv
// Iterative restoring divider, one quotient bit per clock.
// Divides magnitudes, then applies truncate-toward-zero signs in FIX.
module div_ss
    import math_pkg::*;
#(
    parameter int ADw = 8,
    parameter int BDw = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_pi,
    input  logic [1:0]     tc_mode_i,
    input  logic [ADw-1:0] a_i,
    input  logic [BDw-1:0] b_i,
    output logic [ADw-1:0] q_o,
    output logic [BDw:0]   r_o,
    output logic           div_zero_o,
    output logic           valid_o,
    output logic           busy_o
);

    localparam int CW = $clog2(ADw) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ADw - 1);

    div_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_sa;
    logic           r_sb;
    logic [ADw-1:0] r_a;
    logic [BDw-1:0] r_b;
    logic [BDw:0]   r_rem;
    logic [BDw:0]   r_alo;
    logic [ADw-1:0] r_q;
    logic [BDw:0]   r_r;
    logic           r_dz;
    logic           r_valid;
    logic           r_busy;

    tc_mode_e       w_mode;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [ADw-1:0] w_a_abs;
    logic [BDw-1:0] w_b_abs;
    logic [BDw:0]   w_rem_nxt;
    logic           w_qbit;
    logic [ADw-1:0] w_q_fix;
    logic [BDw:0]   w_r_fix;

    // Operand magnitudes; a negative value needs a signed mode and a set MSB
    always_comb begin
        w_mode  = tc_mode_e'(tc_mode_i);
        w_a_neg = ((w_mode == TC_SU) || (w_mode == TC_SS)) && a_i[ADw-1];
        w_b_neg = ((w_mode == TC_US) || (w_mode == TC_SS)) && b_i[BDw-1];
        w_a_abs = w_a_neg ? -a_i : a_i;
        w_b_abs = w_b_neg ? -b_i : b_i;
    end

    div_ss_step #(
        .BDw   (BDw)
    ) u_step (
        .i_rem (r_rem[BDw-1:0]),
        .i_bit (r_a[ADw-1]),
        .i_b   (r_b),
        .o_rem (w_rem_nxt),
        .o_q   (w_qbit)
    );

    // Quotient negative iff signs differ; remainder follows the dividend
    always_comb begin
        w_q_fix = (r_sa ^ r_sb) ? -r_a : r_a;
        w_r_fix = r_sa ? -r_rem : r_rem;
    end

    // Control FSM; r_a shifts |a| out of its MSB while quotient bits enter the LSB
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_alo   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (en_pi) begin
                        r_sa    <= w_a_neg;
                        r_sb    <= w_b_neg;
                        r_a     <= w_a_abs;
                        r_b     <= w_b_abs;
                        r_alo   <= a_i[BDw:0];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_a   <= {r_a[ADw-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (r_b == '0) begin
                        r_q  <= '1;
                        r_r  <= r_alo;
                        r_dz <= 1'b1;
                    end else begin
                        r_q  <= w_q_fix;
                        r_r  <= w_r_fix;
                        r_dz <= 1'b0;
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign q_o        = r_q;
    assign r_o        = r_r;
    assign div_zero_o = r_dz;
    assign valid_o    = r_valid;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_div_ss.sv
// Self-checking bench for div_ss.
// Compares against an integer-arithmetic reference model.
module tb_div_ss;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] tc = 2'b00;
    logic [7:0] a = 8'h00;
    logic [3:0] b = 4'h0;
    logic [7:0] q;
    logic [4:0] r;
    logic       dz;
    logic       valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ss #(
        .ADw        (8),
        .BDw        (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_pi      (en),
        .tc_mode_i  (tc),
        .a_i        (a),
        .b_i        (b),
        .q_o        (q),
        .r_o        (r),
        .div_zero_o (dz),
        .valid_o    (valid),
        .busy_o     (busy)
    );

    // Truncating division in plain integer arithmetic
    function automatic void ref_div(
        input  logic [1:0] m,
        input  logic [7:0] av_in,
        input  logic [3:0] bv_in,
        output logic [7:0] eq,
        output logic [4:0] er,
        output logic       edz
    );
        int av;
        int bv;
        logic [31:0] tq;
        logic [31:0] tr;
        av = m[0] ? int'($signed(av_in)) : int'(av_in);
        bv = m[1] ? int'($signed(bv_in)) : int'(bv_in);
        if (bv == 0) begin
            eq  = 8'hFF;
            er  = av_in[4:0];
            edz = 1'b1;
        end else begin
            tq  = av / bv;
            tr  = av % bv;
            eq  = tq[7:0];
            er  = tr[4:0];
            edz = 1'b0;
        end
    endfunction

    // Pulse en for one accept edge, then wait for valid; lat counts negedges
    task automatic run_op(input logic [1:0] m, input logic [7:0] av,
                          input logic [3:0] bv, output int lat);
        @(negedge clk);
        tc = m;
        a  = av;
        b  = bv;
        en = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        lat = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({q, r, dz, valid, busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h dz=%b v=%b busy=%b, want all 0",
                     q, r, dz, valid, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0] tm [5] = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b00};
        logic [7:0] ta [5] = '{8'd200, 8'hF9, 8'h9C, 8'h80, 8'h5A};
        logic [3:0] tb [5] = '{4'd7, 4'h2, 4'hF, 4'hF, 4'h0};
        logic [7:0] eq [5] = '{8'd28, 8'hFD, 8'hFA, 8'h80, 8'hFF};
        logic [4:0] er [5] = '{5'h04, 5'h1F, 5'h16, 5'h00, 5'h1A};
        logic       ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(tm[i], ta[i], tb[i], lat);
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 9", i, lat);
            end
            checks++;
            if ({q, r, dz} !== {eq[i], er[i], ez[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, q, r, dz, eq[i], er[i], ez[i]);
            end
        end
    endtask

    task automatic test_busy();
        int n;
        @(negedge clk);
        tc = 2'b00;
        a  = 8'd100;
        b  = 4'd3;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: got busy=%b valid=%b, want 1 0", busy, valid);
        end
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_valid: got busy=%b valid=%b, want 0 1", busy, valid);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got valid=%b, want 0", valid);
        end
    endtask

    task automatic test_abort();
        int seen;
        int lat;
        @(negedge clk);
        tc = 2'b00;
        a  = 8'd200;
        b  = 4'd7;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        a  = 8'd13;
        b  = 4'd5;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || q !== 8'h00) begin
            errors++;
            $display("FAIL abort_state: got busy=%b valid=%b q=%h, want 0 0 00",
                     busy, valid, q);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses, want 0", seen);
        end
        run_op(2'b11, 8'hF9, 4'h2, lat);
        checks++;
        if (lat != 9 || {q, r, dz} !== {8'hFD, 5'h1F, 1'b0}) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d q=%h r=%h dz=%b, want 9 fd 1f 0",
                     lat, q, r, dz);
        end
    endtask

    task automatic test_operand_hold();
        logic [7:0] eq;
        logic [4:0] er;
        logic       ez;
        logic [1:0] m0;
        logic [7:0] a0;
        logic [3:0] b0;
        int n;
        int bad;
        m0 = 2'($urandom);
        a0 = 8'($urandom);
        b0 = 4'($urandom_range(1, 15));
        ref_div(m0, a0, b0, eq, er, ez);
        @(negedge clk);
        tc = m0;
        a  = a0;
        b  = b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (!valid && n < 20) begin
            tc = 2'($urandom);
            a  = 8'($urandom);
            b  = 4'($urandom);
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20 || {q, r, dz} !== {eq, er, ez}) begin
            errors++;
            $display("FAIL operand_hold: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     q, r, dz, eq, er, ez);
        end
        bad = 0;
        repeat (6) begin
            a = 8'($urandom);
            @(negedge clk);
            if ({q, r, dz} !== {eq, er, ez}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL result_hold: %0d cycles changed, want 0", bad);
        end
    endtask

    // en held high so each op is accepted in the previous op's valid cycle
    task automatic test_back_to_back(input logic [1:0] m, input bit full, input int n);
        logic [7:0] ca;
        logic [3:0] cb;
        logic [7:0] eq;
        logic [4:0] er;
        logic       ez;
        int cyc;
        @(negedge clk);
        tc = m;
        if (full) begin
            a = 8'd0;
            b = 4'd0;
        end else begin
            a = 8'($urandom);
            b = 4'($urandom);
        end
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            ca  = a;
            cb  = b;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!valid && cyc < 20);
            checks++;
            if (!valid) begin
                errors++;
                $display("FAIL b2b_timeout: mode=%b op %0d no valid in 20 cycles", m, i);
                break;
            end
            ref_div(m, ca, cb, eq, er, ez);
            if ({q, r, dz} !== {eq, er, ez}) begin
                errors++;
                $display("FAIL b2b_mode%b a=%h b=%h: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         m, ca, cb, q, r, dz, eq, er, ez);
                break;
            end
            if (i + 1 < n) begin
                if (full) begin
                    a = 8'((i + 1) >> 4);
                    b = 4'(i + 1);
                end else begin
                    a = 8'($urandom);
                    b = 4'($urandom);
                end
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_abort();
        test_operand_hold();
        test_back_to_back(2'b11, 1'b1, 4096);
        test_back_to_back(2'b00, 1'b0, 700);
        test_back_to_back(2'b01, 1'b0, 700);
        test_back_to_back(2'b10, 1'b0, 700);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
